y86_wb_regfile: RTL and testbench
=================================

Name: y86_wb_regfile

Overview:
- Parametrised successor to the sequential Y86 write-back stage.
- Decodes the write destinations from icode/rA/rB/cnd internally and owns the register file, with two write ports (E and M) and two read ports (A and B).
- Tracks processor run/halt state and counts retired instructions.
- Sits between the memory stage and decode; decode reads srcA/srcB from it.

Parameters:
DATA_W, 64, register width in bits
NUM_REGS, 15, implemented registers (ids 0..NUM_REGS-1); id 4'hF = RNONE
RET_CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous active-high reset
wb_valid  in  1  current instruction is valid and retires this cycle
icode  in  4  instruction code
rA  in  4  register id field A
rB  in  4  register id field B
cnd  in  1  condition result from execute (cmovxx)
stat  in  2  instruction status: 0 AOK, 1 HLT, 2 ADR, 3 INS
valE  in  DATA_W  ALU result
valM  in  DATA_W  memory read data
srcA  in  4  read port A id
srcB  in  4  read port B id
valA  out  DATA_W  read data A
valB  out  DATA_W  read data B
halted  out  1  processor stopped
halt_stat  out  2  stat that caused the halt
ret_cnt  out  RET_CNT_W  retired-instruction count

Behaviour:
- Reset (async): all registers 0, state RUN, halted=0, halt_stat=0, ret_cnt=0.
- dstE decode:
  - cmovxx (2): rB if cnd, else RNONE.
  - irmovq (3) and OPq (6): rB.
  - call (8), ret (9), pushq (A), popq (B): 4 (%rsp).
  - All other icodes: RNONE.
- dstM decode: mrmovq (5) and popq (B): rA; otherwise RNONE.
- Write enable: state==RUN && wb_valid && stat==AOK && dst!=RNONE && dst<NUM_REGS. Writes with dst>=NUM_REGS are dropped silently.
- Both writes commit at the same posedge. If dstE==dstM (popq %rsp), valM wins.
- Reads are combinational from the array. srcA/srcB of RNONE or >=NUM_REGS return 0.
- State machine:
  - RUN -> HALT on posedge when wb_valid && (icode==0 || stat!=AOK); latch halt_stat = (icode==0 && stat==AOK) ? HLT : stat.
  - The halting instruction performs no register write.
  - HALT is sticky until rst: no register writes, ret_cnt frozen.
- ret_cnt:
  - Increments by 1 on posedge when state==RUN && wb_valid && stat==AOK && icode!=0.
  - Saturates at all-ones, no wrap.
- halted = (state==HALT), registered.
- Reset asserted mid-operation clears everything immediately. The first posedge after deassertion may write.

Optional Feature:
- Macro WB_REGFILE_BYPASS_EN.
- Defined: read ports are write-through. If srcX matches an enabled same-cycle dstM, valX = valM; else if it matches dstE, valX = valE; else the array value. Priority M over E.
- Undefined: reads return array contents only; the written value is visible after the posedge.

Decomposition:
- Shared package y86_pkg:
  - icode constants (I_HALT..I_POPQ).
  - REG_RSP=4, REG_NONE=4'hF.
  - stat enum (STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS).
  - Run/halt state enum.
- Sub-module y86_wb_dst_decode: combinational icode/rA/rB/cnd -> dstE/dstM, reused by the pipelined hazard unit.

Test Plan:
1. irmovq: rst pulse; wb_valid=1, icode=3, rB=2, valE=0x1234, stat=0 -> after posedge, srcA=2 gives valA=0x1234; ret_cnt=1.
2. cmov: icode=2, rB=3, valE=0x55, cnd=0 -> reg3 stays 0; repeat with cnd=1 -> reg3=0x55.
3. popq %rsp: icode=B, rA=4, valE=0x100, valM=0x200 -> reg4=0x200. Also icode=B, rA=1: reg4=0x100 and reg1=0x200 in the same cycle.
4. halt: icode=0, wb_valid=1 -> halted=1, halt_stat=1. A following irmovq rB=5 valE=9 leaves reg5=0; ret_cnt unchanged. Asserting rst mid-cycle clears halted and all registers at once, without waiting for a clock edge.
5. Bypass (with WB_REGFILE_BYPASS_EN): icode=6, rB=7, valE=0xAB, srcB=7 in the same cycle -> valB=0xAB before the posedge. Without the macro, valB=0 until the posedge.
6. Edge cases:
   - Write to rB=14 succeeds; write to rB=15 is ignored.
   - stat=3 with wb_valid -> halt_stat=3, no write.
   - Force ret_cnt to all-ones via RET_CNT_W=2 and 4 retirements -> holds at 3.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, register ids, status codes and
// the run/halt state used by the write-back stage and the hazard unit.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_e;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } run_state_e;

endpackage

// File: rtl/y86_wb_dst_decode.sv
// Combinational write-destination decode (dstE/dstM) from icode/rA/rB/cnd.
module y86_wb_dst_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  input  logic       cnd,
  output logic [3:0] dst_e,
  output logic [3:0] dst_m
);

  always_comb begin
    dst_e = REG_NONE;
    case (icode)
      I_RRMOVQ:                        dst_e = cnd ? rB : REG_NONE;
      I_IRMOVQ, I_OPQ:                 dst_e = rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:  dst_e = REG_RSP;
      default:                         dst_e = REG_NONE;
    endcase
  end

  always_comb begin
    dst_m = REG_NONE;
    if (icode == I_MRMOVQ || icode == I_POPQ) dst_m = rA;
  end

endmodule

// File: rtl/y86_wb_regfile.sv
// Y86 write-back stage with register file, run/halt tracking and retire count.
// Define WB_REGFILE_BYPASS_EN to make the read ports write-through.
module y86_wb_regfile
  import y86_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int NUM_REGS  = 15,
  parameter int RET_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid,
  input  logic [3:0]           icode,
  input  logic [3:0]           rA,
  input  logic [3:0]           rB,
  input  logic                 cnd,
  input  logic [1:0]           stat,
  input  logic [DATA_W-1:0]    valE,
  input  logic [DATA_W-1:0]    valM,
  input  logic [3:0]           srcA,
  input  logic [3:0]           srcB,
  output logic [DATA_W-1:0]    valA,
  output logic [DATA_W-1:0]    valB,
  output logic                 halted,
  output logic [1:0]           halt_stat,
  output logic [RET_CNT_W-1:0] ret_cnt
);

  localparam logic [4:0] NREGS = NUM_REGS[4:0];

  logic [3:0]           dst_e, dst_m;
  logic                 retire_ok, we_e, we_m, halt_now;
  run_state_e           state_q, state_d;
  logic [1:0]           halt_stat_q, halt_stat_d;
  logic [RET_CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [DATA_W-1:0]    regs_d [NUM_REGS];

  y86_wb_dst_decode u_dst_decode (
    .icode (icode),
    .rA    (rA),
    .rB    (rB),
    .cnd   (cnd),
    .dst_e (dst_e),
    .dst_m (dst_m)
  );

  always_comb begin
    retire_ok = (state_q == S_RUN) && wb_valid && (stat == STAT_AOK);
    we_e      = retire_ok && (dst_e != REG_NONE) && ({1'b0, dst_e} < NREGS);
    we_m      = retire_ok && (dst_m != REG_NONE) && ({1'b0, dst_m} < NREGS);
    halt_now  = (state_q == S_RUN) && wb_valid && ((icode == I_HALT) || (stat != STAT_AOK));
  end

  // M is applied after E so popq %rsp keeps the popped value.
  always_comb begin
    regs_d = regs_q;
    if (we_e) regs_d[dst_e] = valE;
    if (we_m) regs_d[dst_m] = valM;
  end

  always_comb begin
    state_d     = state_q;
    halt_stat_d = halt_stat_q;
    ret_cnt_d   = ret_cnt_q;
    if (halt_now) begin
      state_d     = S_HALT;
      halt_stat_d = ((icode == I_HALT) && (stat == STAT_AOK)) ? STAT_HLT : stat;
    end
    if (retire_ok && (icode != I_HALT) && (ret_cnt_q != '1)) ret_cnt_d = ret_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      halt_stat_q <= '0;
      ret_cnt_q   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      halt_stat_q <= halt_stat_d;
      ret_cnt_q   <= ret_cnt_d;
      regs_q      <= regs_d;
    end
  end

  always_comb begin
    valA = '0;
    valB = '0;
    if (srcA != REG_NONE && {1'b0, srcA} < NREGS) valA = regs_q[srcA];
    if (srcB != REG_NONE && {1'b0, srcB} < NREGS) valB = regs_q[srcB];
`ifdef WB_REGFILE_BYPASS_EN
    if (we_m && srcA == dst_m)      valA = valM;
    else if (we_e && srcA == dst_e) valA = valE;
    if (we_m && srcB == dst_m)      valB = valM;
    else if (we_e && srcB == dst_e) valB = valE;
`endif
  end

  assign halted    = (state_q == S_HALT);
  assign halt_stat = halt_stat_q;
  assign ret_cnt   = ret_cnt_q;

endmodule

// File: tb/tb_y86_wb_regfile.sv
// Directed self-checking bench for y86_wb_regfile (default and 2-bit counter builds).
module tb_y86_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [3:0]  icode, rA, rB, srcA, srcB;
  logic        cnd;
  logic [1:0]  stat;
  logic [63:0] valE, valM, valA, valB, valA_s, valB_s;
  logic        halted, halted_s;
  logic [1:0]  halt_stat, halt_stat_s;
  logic [31:0] ret_cnt;
  logic [1:0]  ret_cnt_s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  y86_wb_regfile dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .icode(icode), .rA(rA), .rB(rB),
    .cnd(cnd), .stat(stat), .valE(valE), .valM(valM), .srcA(srcA), .srcB(srcB),
    .valA(valA), .valB(valB), .halted(halted), .halt_stat(halt_stat), .ret_cnt(ret_cnt)
  );

  y86_wb_regfile #(.RET_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .icode(icode), .rA(rA), .rB(rB),
    .cnd(cnd), .stat(stat), .valE(valE), .valM(valM), .srcA(srcA), .srcB(srcB),
    .valA(valA_s), .valB(valB_s), .halted(halted_s), .halt_stat(halt_stat_s), .ret_cnt(ret_cnt_s)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Retire one instruction on the next posedge, then idle the write port.
  task automatic step();
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    #1;
  endtask

  task automatic issue(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [1:0] st,
                       input logic [63:0] e, input logic [63:0] m);
    icode = ic; rA = a; rB = b; cnd = c; stat = st; valE = e; valM = m;
    wb_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; wb_valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF; cnd = 1'b0;
    stat = 2'd0; valE = '0; valM = '0; srcA = 4'h2; srcB = 4'h3;
    #12;
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_halt_stat", {62'd0, halt_stat}, 64'd0);
    check("rst_ret_cnt", {32'd0, ret_cnt}, 64'd0);
    check("rst_valA", valA, 64'd0);
    @(negedge clk); rst = 1'b0;

    // irmovq
    issue(4'h3, 4'hF, 4'h2, 1'b0, 2'd0, 64'h1234, 64'h0);
    step();
    srcA = 4'h2; #1;
    check("irmovq_valA", valA, 64'h1234);
    check("irmovq_ret", {32'd0, ret_cnt}, 64'd1);

    // cmov not taken / taken
    issue(4'h2, 4'hF, 4'h3, 1'b0, 2'd0, 64'h55, 64'h0);
    step();
    srcB = 4'h3; #1;
    check("cmov_nt_valB", valB, 64'h0);
    issue(4'h2, 4'hF, 4'h3, 1'b1, 2'd0, 64'h55, 64'h0);
    step();
    check("cmov_t_valB", valB, 64'h55);
    check("cmov_ret", {32'd0, ret_cnt}, 64'd3);

    // popq %rsp: valM wins over valE
    issue(4'hB, 4'h4, 4'hF, 1'b0, 2'd0, 64'h100, 64'h200);
    step();
    srcA = 4'h4; #1;
    check("popq_rsp", valA, 64'h200);
    check("sat_ret_at3", {62'd0, ret_cnt_s}, 64'd3);
    issue(4'hB, 4'h1, 4'hF, 1'b0, 2'd0, 64'h100, 64'h200);
    step();
    srcA = 4'h4; srcB = 4'h1; #1;
    check("popq_rsp_e", valA, 64'h100);
    check("popq_r1_m", valB, 64'h200);
    check("sat_ret_hold", {62'd0, ret_cnt_s}, 64'd3);

    // same-cycle read of the register being written
    srcB = 4'h7;
    issue(4'h6, 4'hF, 4'h7, 1'b0, 2'd0, 64'hAB, 64'h0);
    #1;
`ifdef WB_REGFILE_BYPASS_EN
    check("bypass_before_edge", valB, 64'hAB);
`else
    check("nobypass_before_edge", valB, 64'h0);
`endif
    step();
    check("opq_after_edge", valB, 64'hAB);

    // register id boundaries
    issue(4'h3, 4'hF, 4'hE, 1'b0, 2'd0, 64'hE, 64'h0);
    step();
    srcA = 4'hE; #1;
    check("write_r14", valA, 64'hE);
    issue(4'h3, 4'hF, 4'hF, 1'b0, 2'd0, 64'hF, 64'h0);
    step();
    srcA = 4'hF; #1;
    check("read_rnone", valA, 64'h0);
    check("ret_before_halt", {32'd0, ret_cnt}, 64'd8);

    // halt, then sticky
    issue(4'h0, 4'hF, 4'hF, 1'b0, 2'd0, 64'h0, 64'h0);
    step();
    check("halt_halted", {63'd0, halted}, 64'd1);
    check("halt_stat_hlt", {62'd0, halt_stat}, 64'd1);
    check("halt_ret", {32'd0, ret_cnt}, 64'd8);
    issue(4'h3, 4'hF, 4'h5, 1'b0, 2'd0, 64'h9, 64'h0);
    step();
    srcA = 4'h5; #1;
    check("halted_no_write", valA, 64'h0);
    check("halted_ret_frozen", {32'd0, ret_cnt}, 64'd8);
    check("halted_sticky", {63'd0, halted}, 64'd1);

    // asynchronous reset in mid-cycle
    srcA = 4'h2; srcB = 4'h3; #1;
    check("pre_rst_reg2", valA, 64'h1234);
    rst = 1'b1; #1;
    check("async_rst_halted", {63'd0, halted}, 64'd0);
    check("async_rst_reg2", valA, 64'h0);
    check("async_rst_reg3", valB, 64'h0);
    check("async_rst_ret", {32'd0, ret_cnt}, 64'd0);
    check("async_rst_stat", {62'd0, halt_stat}, 64'd0);
    @(negedge clk); rst = 1'b0;

    // error status halts without writing or retiring
    issue(4'h3, 4'hF, 4'h6, 1'b0, 2'd3, 64'h66, 64'h0);
    step();
    srcA = 4'h6; #1;
    check("ins_halted", {63'd0, halted}, 64'd1);
    check("ins_halt_stat", {62'd0, halt_stat}, 64'd3);
    check("ins_no_write", valA, 64'h0);
    check("ins_no_retire", {32'd0, ret_cnt}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
